// File: rtl/priority_resolver_irr.sv
// -----------------------------------------------------------------------------
// priority_resolver_irr
//
// Request side of the 8259A PIC. The raw IR0-IR7 lines are synchronised and
// captured in the Interrupt Request Register (IRR). Pending requests are then
// resolved against the OCW1 mask and the in-service bits using fully nested,
// rotating priority. The winner drives INT and is latched into toSet on the
// first INTA pulse (readPriority) for the in-service register.
//
// Parameters
//   SYNC_STAGES     flip-flop stages on each irIn line (minimum 1)
//
// Ports
//   clk             system clock, rising-edge active
//   reset           asynchronous, active-high reset
//   irIn[7:0]       raw interrupt request lines (asynchronous)
//   levelTriggered  1 = level-sensitive capture, 0 = edge-sensitive capture
//   imr[7:0]        interrupt mask, 1 = masked (resolution only)
//   isrRegValue[7:0] in-service bits from the in-service register
//   readPriority    one-cycle pulse at first INTA; latches the winner
//   EOI             end-of-interrupt level from the in-service register
//   resetedIndex[2:0] ISR bit just cleared, valid while EOI = 1
//   rotateOnEoi     rotate priority on the EOI rising edge
//   setPriority     one-cycle pulse: make priorityLevel the lowest priority
//   priorityLevel[2:0] level that becomes lowest priority on setPriority
//   INT             registered interrupt request to the CPU
//   toSet[2:0]      latched winning index (7 on a spurious acknowledge)
//   zeroLevelIndex[2:0] index currently holding the highest priority
//   irrValue[7:0]   IRR contents
// -----------------------------------------------------------------------------
module priority_resolver_irr #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irIn,
    input  logic       levelTriggered,
    input  logic [7:0] imr,
    input  logic [7:0] isrRegValue,
    input  logic       readPriority,
    input  logic       EOI,
    input  logic [2:0] resetedIndex,
    input  logic       rotateOnEoi,
    input  logic       setPriority,
    input  logic [2:0] priorityLevel,
    output logic       INT,
    output logic [2:0] toSet,
    output logic [2:0] zeroLevelIndex,
    output logic [7:0] irrValue
);

    // Synchroniser chain; the last stage is irSync, one more flop gives irPrev.
    logic [7:0] syncChain [SYNC_STAGES];
    logic [7:0] irSync;
    logic [7:0] irPrev;

    logic [7:0] irr;
    logic [7:0] irrNext;
    logic       eoiPrev;
    logic       eoiRise;

    logic       winnerValid;
    logic [2:0] winner;
    logic [7:0] ackMask;

    assign irSync   = syncChain[SYNC_STAGES-1];
    assign irrValue = irr;
    assign eoiRise  = EOI & ~eoiPrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                syncChain[s] <= '0;
            end
            irPrev <= '0;
        end else begin
            syncChain[0] <= irIn;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                syncChain[s] <= syncChain[s-1];
            end
            irPrev <= irSync;
        end
    end

    // Rotating scan starting at the highest-priority index. An in-service bit
    // ends the scan first, so a request at the same level as an in-service
    // one cannot win.
    always_comb begin
        logic       stop;
        logic [2:0] idx;
        winnerValid = 1'b0;
        winner      = '0;
        stop        = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = zeroLevelIndex + 3'(k);
            if (!stop) begin
                if (isrRegValue[idx]) begin
                    stop = 1'b1;
                end else if (irr[idx] && !imr[idx]) begin
                    winnerValid = 1'b1;
                    winner      = idx;
                    stop        = 1'b1;
                end
            end
        end
    end

    assign ackMask = (readPriority && winnerValid) ? (8'b1 << winner) : '0;

    // Acknowledge beats a coincident rising edge; in edge mode the held-high
    // line then looks like "no new edge" and the bit stays clear.
    always_comb begin
        irrNext = irr;
        for (int unsigned i = 0; i < 8; i++) begin
            if (ackMask[i]) begin
                irrNext[i] = 1'b0;
            end else if (levelTriggered) begin
                irrNext[i] = irSync[i];
            end else if (!irSync[i]) begin
                irrNext[i] = 1'b0;
            end else if (!irPrev[i]) begin
                irrNext[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr            <= '0;
            INT            <= 1'b0;
            toSet          <= '0;
            zeroLevelIndex <= '0;
            eoiPrev        <= 1'b0;
        end else begin
            irr     <= irrNext;
            INT     <= winnerValid;
            eoiPrev <= EOI;
            if (readPriority) begin
                toSet <= winnerValid ? winner : 3'd7;
            end
            if (setPriority) begin
                zeroLevelIndex <= priorityLevel + 3'd1;
            end else if (eoiRise && rotateOnEoi) begin
                zeroLevelIndex <= resetedIndex + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_priority_resolver_irr.sv
// -----------------------------------------------------------------------------
// tb_priority_resolver_irr
//
// Directed scenarios followed by a randomized phase, every cycle compared with
// a behavioural model of the request register and priority resolution.
// -----------------------------------------------------------------------------
module tb_priority_resolver_irr;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irIn;
    logic       levelTriggered;
    logic [7:0] imr;
    logic [7:0] isrRegValue;
    logic       readPriority;
    logic       EOI;
    logic [2:0] resetedIndex;
    logic       rotateOnEoi;
    logic       setPriority;
    logic [2:0] priorityLevel;
    logic       INT;
    logic [2:0] toSet;
    logic [2:0] zeroLevelIndex;
    logic [7:0] irrValue;

    int nChecks = 0;
    int nErrors = 0;

    // Model state
    logic [7:0] hist[$];
    logic [7:0] mIrr;
    logic       mInt;
    logic [2:0] mToSet;
    logic [2:0] mZli;
    logic       mEoiPrev;

    priority_resolver_irr #(.SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .reset         (reset),
        .irIn          (irIn),
        .levelTriggered(levelTriggered),
        .imr           (imr),
        .isrRegValue   (isrRegValue),
        .readPriority  (readPriority),
        .EOI           (EOI),
        .resetedIndex  (resetedIndex),
        .rotateOnEoi   (rotateOnEoi),
        .setPriority   (setPriority),
        .priorityLevel (priorityLevel),
        .INT           (INT),
        .toSet         (toSet),
        .zeroLevelIndex(zeroLevelIndex),
        .irrValue      (irrValue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back(8'h00);
        mIrr = '0; mInt = 0; mToSet = '0; mZli = '0; mEoiPrev = 0;
    endtask

    // Highest-priority pending, unmasked request, counting down the priority
    // ranking from zli; reaching any in-service level first means no winner.
    function automatic void resolve(input logic [7:0] r, input logic [7:0] m,
                                    input logic [7:0] s, input logic [2:0] z,
                                    output logic v, output logic [2:0] w);
        bit done = 0;
        v = 0; w = 0;
        for (int rank = 0; rank < 8; rank++) begin
            int lvl = (int'(z) + rank) % 8;
            if (!done) begin
                if (s[lvl]) done = 1;
                else if (r[lvl] && !m[lvl]) begin
                    v = 1; w = 3'(lvl); done = 1;
                end
            end
        end
    endfunction

    task automatic checkAll(input string tag);
        check({tag, ".irr"},   irrValue,               mIrr);
        check({tag, ".int"},   {7'd0, INT},            {7'd0, mInt});
        check({tag, ".toSet"}, {5'd0, toSet},          {5'd0, mToSet});
        check({tag, ".zli"},   {5'd0, zeroLevelIndex}, {5'd0, mZli});
    endtask

    // One clock: predict from pre-edge state and inputs, advance, compare.
    task automatic cycle(input string tag);
        logic       v;
        logic [2:0] w;
        logic [7:0] sy, pv, nIrr;
        logic [2:0] nToSet, nZli;
        resolve(mIrr, imr, isrRegValue, mZli, v, w);
        sy = hist[SS-1];
        pv = hist[SS];
        for (int i = 0; i < 8; i++) begin
            if (readPriority && v && int'(w) == i) nIrr[i] = 0;
            else if (levelTriggered)               nIrr[i] = sy[i];
            else if (!sy[i])                       nIrr[i] = 0;
            else if (!pv[i])                       nIrr[i] = 1;
            else                                   nIrr[i] = mIrr[i];
        end
        nToSet = readPriority ? (v ? w : 3'd7) : mToSet;
        if (setPriority)                          nZli = 3'((int'(priorityLevel) + 1) % 8);
        else if (EOI && !mEoiPrev && rotateOnEoi) nZli = 3'((int'(resetedIndex) + 1) % 8);
        else                                      nZli = mZli;
        @(posedge clk);
        hist.push_front(irIn);
        void'(hist.pop_back());
        mIrr = nIrr; mInt = v; mToSet = nToSet; mZli = nZli; mEoiPrev = EOI;
        #1;
        checkAll(tag);
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic ackPulse(input string tag);
        readPriority = 1;
        cycle(tag);
        readPriority = 0;
    endtask

    task automatic doReset();
        reset = 1;
        #1;
        check("rst.irr",   irrValue, 8'h00);
        check("rst.int",   {7'd0, INT}, 8'h00);
        check("rst.toSet", {5'd0, toSet}, 8'h00);
        check("rst.zli",   {5'd0, zeroLevelIndex}, 8'h00);
        @(posedge clk);
        #1;
        reset = 0;
        modelClear();
    endtask

    initial begin
        reset = 1; irIn = 0; levelTriggered = 0; imr = 0; isrRegValue = 0;
        readPriority = 0; EOI = 0; resetedIndex = 0; rotateOnEoi = 0;
        setPriority = 0; priorityLevel = 0;
        modelClear();
        #2;
        doReset();

        // Edge capture
        irIn = 8'h08;
        cycles(3, "edge");
        check("edge.irr3", irrValue, 8'h08);
        check("edge.int3", {7'd0, INT}, 8'h00);
        cycle("edge");
        check("edge.int4", {7'd0, INT}, 8'h01);
        ackPulse("edgeAck");
        check("edge.toSet", {5'd0, toSet}, 8'h03);
        check("edge.irrAck", irrValue, 8'h00);
        cycle("edgeAck");
        check("edge.intDrop", {7'd0, INT}, 8'h00);
        irIn = 0;
        cycles(4, "idle");

        // Priority and nesting
        irIn = 8'h24;
        cycles(4, "prio");
        ackPulse("prioAck");
        check("prio.toSet2", {5'd0, toSet}, 8'h02);
        check("prio.irr20", irrValue, 8'h20);
        isrRegValue = 8'h04;
        cycles(2, "nest");
        check("nest.int0", {7'd0, INT}, 8'h00);
        isrRegValue = 8'h00;
        cycle("nest");
        check("nest.int1", {7'd0, INT}, 8'h01);
        ackPulse("nestAck");
        check("nest.toSet5", {5'd0, toSet}, 8'h05);
        irIn = 0;
        cycles(4, "idle");

        // Masking
        irIn = 8'h81; imr = 8'h01;
        cycles(4, "mask");
        ackPulse("maskAck");
        check("mask.toSet7", {5'd0, toSet}, 8'h07);
        check("mask.irr01", irrValue, 8'h01);
        imr = 8'hFF;
        cycles(2, "maskAll");
        check("maskAll.int", {7'd0, INT}, 8'h00);
        ackPulse("spurious");
        check("spur.toSet", {5'd0, toSet}, 8'h07);
        check("spur.irr", irrValue, 8'h01);
        imr = 0; irIn = 0;
        cycles(4, "idle");

        // Rotation
        rotateOnEoi = 1; EOI = 1; resetedIndex = 3'd4;
        cycle("rotEoi");
        EOI = 0;
        check("rot.zli5", {5'd0, zeroLevelIndex}, 8'h05);
        irIn = 8'h21;
        cycles(4, "rot");
        ackPulse("rotAck");
        check("rot.toSet5", {5'd0, toSet}, 8'h05);
        setPriority = 1; priorityLevel = 3'd7; EOI = 1; resetedIndex = 3'd2;
        cycle("rotBoth");
        setPriority = 0; EOI = 0;
        check("rot.zli0", {5'd0, zeroLevelIndex}, 8'h00);
        irIn = 0;
        cycles(4, "idle");

        // Level mode
        levelTriggered = 1; irIn = 8'h40;
        cycles(4, "lvl");
        ackPulse("lvlAck");
        check("lvl.cleared", irrValue, 8'h00);
        cycle("lvl");
        check("lvl.reset", irrValue, 8'h40);
        irIn = 0;
        cycles(3, "lvlDrop");
        check("lvl.dropIrr", irrValue, 8'h00);
        cycle("lvlDrop");
        check("lvl.dropInt", {7'd0, INT}, 8'h00);

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) levelTriggered = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) irIn = 8'($urandom);
            imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            isrRegValue = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            readPriority = ($urandom_range(0, 4) == 0);
            EOI = 1'($urandom_range(0, 1));
            resetedIndex = 3'($urandom);
            rotateOnEoi = 1'($urandom_range(0, 1));
            setPriority = ($urandom_range(0, 9) == 0);
            priorityLevel = 3'($urandom);
            cycle("rand");
        end
        readPriority = 0; setPriority = 0; EOI = 0; imr = 0; isrRegValue = 0;
        irIn = 0;

        // Reset in the middle of operation
        doReset();
        levelTriggered = 0; rotateOnEoi = 0;
        setPriority = 1; priorityLevel = 3'd4;
        cycle("mid");
        setPriority = 0;
        irIn = 8'h18;
        cycles(4, "mid");
        ackPulse("midAck");
        cycle("mid");
        check("mid.int", {7'd0, INT}, 8'h01);
        check("mid.toSet", {5'd0, toSet}, 8'h03);
        check("mid.zli", {5'd0, zeroLevelIndex}, 8'h05);
        #2;
        reset = 1;
        #1;
        check("midRst.irr",   irrValue, 8'h00);
        check("midRst.int",   {7'd0, INT}, 8'h00);
        check("midRst.toSet", {5'd0, toSet}, 8'h00);
        check("midRst.zli",   {5'd0, zeroLevelIndex}, 8'h00);
        @(posedge clk);
        #1;
        reset = 0;
        irIn = 0;
        modelClear();
        cycles(3, "post");

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/priority_resolver_irr.md
Name: priority_resolver_irr

Overview:
Upstream neighbour of the in-service register in the 8259A PIC. It synchronises the raw IR0-IR7 request lines and captures them in the Interrupt Request Register (IRR). It applies the OCW1 mask and resolves the highest-priority pending request against the in-service bits using fully nested, rotating priority. It raises INT, and presents the winning index (toSet) and the current highest-priority level (zeroLevelIndex) that the in-service register consumes.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on each irIn line (minimum 1).

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
irIn  input  8  raw interrupt request lines IR0-IR7 (asynchronous)
levelTriggered  input  1  ICW1 LTIM: 1 = level mode, 0 = edge mode
imr  input  8  OCW1 interrupt mask, 1 = masked
isrRegValue  input  8  current in-service bits from the in-service register
readPriority  input  1  one-cycle pulse issued at first INTA; latches the winner
EOI  input  1  end-of-interrupt level from the in-service register
resetedIndex  input  3  index of the ISR bit just cleared, valid while EOI=1
rotateOnEoi  input  1  OCW2 R bit: rotate priority on EOI
setPriority  input  1  one-cycle pulse: OCW2 set-priority command
priorityLevel  input  3  OCW2 L2-L0: level that becomes lowest priority
INT  output  1  interrupt request to the CPU
toSet  output  3  latched winning IR index, to the in-service register
zeroLevelIndex  output  3  index currently holding highest priority
irrValue  output  8  IRR contents, for the read-IRR path

Behaviour:
- Reset (asynchronous) clears: synchroniser flops, previous-sample flops, irr, INT, toSet, zeroLevelIndex, and the EOI edge flop. Outputs are not updated during reset.
- Synchroniser: irSync is irIn delayed by SYNC_STAGES flops. irPrev is irSync delayed by one further flop.
- IRR update, per bit i, evaluated in this priority order:
  - Edge mode: clear if acknowledged this cycle. Else clear if irSync[i]=0 (request withdrawn before acknowledge). Else set if irSync[i]=1 and irPrev[i]=0. Else hold.
  - Level mode: clear if acknowledged this cycle. Else irr[i] follows irSync[i].
- Resolution (combinational, from registered state):
  - Scan k = 0..7 over index j = (zeroLevelIndex + k) mod 8.
  - The first j with isrRegValue[j]=1 stops the scan with no winner. A pending request must not preempt an equal or higher in-service level.
  - The first j with irr[j] & ~imr[j] = 1, met before any in-service bit, is the winner.
- INT: registered; INT <= winnerValid every cycle. Latency is one cycle from the irr change, so the first IR edge reaches INT after SYNC_STAGES+2 clocks.
- readPriority pulse:
  - If winnerValid: toSet <= winner, irr[winner] cleared (this is the "acknowledged" case above), INT drops on the following cycle if no other winner remains.
  - If no winner (spurious): toSet <= 7 and irr is unchanged.
  - toSet holds its value between pulses.
- Rotation:
  - eoiRise = EOI & ~eoiPrev.
  - On eoiRise with rotateOnEoi=1: zeroLevelIndex <= resetedIndex + 1 (3-bit wrap, so 7 goes to 0).
  - On a setPriority pulse: zeroLevelIndex <= priorityLevel + 1 (wrap).
  - If both occur in the same cycle, setPriority wins.
- Simultaneous events:
  - readPriority and a new rising edge on the winning bit in the same cycle: the clear wins, and edge mode requires a fresh rising edge to re-set the bit.
  - Level mode: the bit re-sets on the next cycle if the line is still high.
- Masking: imr affects only resolution, never irr capture. Unmasking a pending bit raises INT one cycle later.
- irrValue = irr, registered, with no extra latency.

Test Plan:
- Edge capture: after reset, pulse irIn=8'h08 high and hold; with SYNC_STAGES=2, irrValue=8'h08 three clocks after the edge and INT=1 the clock after. Pulse readPriority: toSet=3, irrValue=8'h00, INT=0 next cycle.
- Priority and nesting: irr=8'h24, isrRegValue=8'h00, zeroLevelIndex=0: readPriority gives toSet=2. Then set isrRegValue=8'h04 with irr=8'h20: INT stays 0. Set isrRegValue=8'h00: INT=1 and readPriority gives toSet=5.
- Masking: irr=8'h81, imr=8'h01: winner is 7, toSet=7 on readPriority. With imr=8'hFF: INT=0; a readPriority pulse gives toSet=7 (spurious) and irrValue stays 8'h01.
- Rotation: rotateOnEoi=1, EOI rises with resetedIndex=4: zeroLevelIndex=5. Then irr=8'h21: toSet=5 on readPriority. setPriority with priorityLevel=7 in the same cycle as an EOI rise: zeroLevelIndex=0.
- Level mode: levelTriggered=1, irIn[6] held high: acknowledge clears irr[6] for one cycle, then it re-sets. If irIn[6] drops before acknowledge, irr[6]=0 and INT=0.
- Reset mid-operation: with INT=1, toSet=3 and zeroLevelIndex=5, assert reset between clock edges: all outputs read 0 immediately, without waiting for a clock edge.
